skew_scheduler: RTL and testbench
=================================

SKEW_SCHEDULER -- requirements
Module: skew_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of skewed input lanes, each feeding one downstream shift register.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the maximum vectors per job.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning the per-lane buffer address width; ADDR_W >= $clog2(DEPTH).
REQ-004 SHALL have parameter PIPE_LAT, default 4, meaning the drain cycles after the last feed (the downstream shift-register length).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, the job request pulse.
REQ-008 SHALL have port abort, input, 1 bit, which cancels the running job.
REQ-009 SHALL have port cfg_len, input, $clog2(DEPTH+1) bits, the vectors per job.
REQ-010 SHALL have port lane_ren_n, output, LANES bits, the per-lane active-low read enable to the shift-register din stage.
REQ-011 SHALL have port lane_addr, output, LANES*ADDR_W bits, the packed per-lane buffer read address; lane i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port busy, output, 1 bit, high in FEED or DRAIN.
REQ-013 SHALL have port done, output, 1 bit, a one-cycle job-complete pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, FEED, DRAIN and DONE; all outputs SHALL be decoded from registered state and counters only, with no combinational path from inputs.
REQ-015 IDLE: start=1 with cfg_len>0 SHALL latch len=min(cfg_len,DEPTH), clear cyc to 0 and go to FEED; start with cfg_len=0 SHALL go directly to DONE.
REQ-016 FEED: cyc SHALL increment by 1 each cycle; after cyc = len+LANES-2 the FSM SHALL go to DRAIN.
REQ-017 Lane i in FEED: lane_ren_n[i]=0 and lane i address = cyc-i when i <= cyc <= i+len-1; otherwise lane_ren_n[i]=1 and lane i address = 0.
REQ-018 DRAIN: SHALL last exactly PIPE_LAT cycles with all lane_ren_n=1, then go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Outside FEED, lane_ren_n SHALL be all ones and lane_addr all zeros.
REQ-021 start while not in IDLE SHALL be ignored and not queued; cfg_len changes after the start-sampling edge SHALL have no effect.
REQ-022 abort=1 in FEED or DRAIN SHALL return the FSM to IDLE on the next edge with no done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-023 When abort and start are both high in FEED or DRAIN, abort SHALL win.
REQ-024 When start and abort are both high in IDLE, the job SHALL start.
REQ-025 Counters SHALL be sized to hold DEPTH+LANES-1 without wrap-around.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, cyc=0, len=0, lane_ren_n=all ones, lane_addr=0, busy=0 and done=0.
REQ-027 Reset asserted mid-job SHALL discard the job; no done pulse SHALL follow release.
REQ-028 The first start SHALL be sampled on the first clock edge after rst_n deasserts.

Configuration
REQ-029 SHALL provide macro SKEW_SCHED_PERF_EN.
REQ-030 With SKEW_SCHED_PERF_EN defined: SHALL add output perf_cycles, 32 bits, reset to 0.
REQ-031 perf_cycles SHALL be cleared on each accepted start, increment each busy cycle, saturate at 0xFFFFFFFF, and hold its value after done or abort.
REQ-032 Without SKEW_SCHED_PERF_EN: the port and its counter SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
Parameters LANES=4, PIPE_LAT=4; cycle n = the n-th edge after the start-sampling edge.
REQ-033 SHALL cover a basic job: cfg_len=3 -> lane0 ren_n low at cycles 1-3 with addr 0,1,2; lane3 ren_n low at cycles 4-6 with addr 0,1,2; busy high at cycles 1-10; done high at cycle 11 only.
REQ-034 SHALL cover the length boundaries: cfg_len=0 -> done at cycle 1, busy never high; cfg_len=DEPTH+3 -> behaves as DEPTH=8, last lane3 enable at cycle 11.
REQ-035 SHALL cover abort: abort at cycle 5 of a cfg_len=3 job -> state IDLE at cycle 6, all ren_n=1, no done; a new start at cycle 6 is accepted.
REQ-036 SHALL cover start while busy: start pulsed at cycles 2 and 9 -> ignored; exactly one done at cycle 11.
REQ-037 SHALL cover reset mid-job: rst_n low at cycle 4 for 2 cycles -> outputs at reset values immediately, no done after release.
REQ-038 SHALL cover the performance counter: with SKEW_SCHED_PERF_EN and cfg_len=3 -> perf_cycles=10 after done, and still 10 while idle.

Source files
------------

// File: rtl/skew_scheduler.sv
// rtl/skew_scheduler.sv - skewed multi-lane read scheduler feeding downstream shift registers (optional SKEW_SCHED_PERF_EN busy-cycle counter)
module skew_scheduler #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [$clog2(DEPTH+1)-1:0]  cfg_len,
  output logic [LANES-1:0]            lane_ren_n,
  output logic [LANES*ADDR_W-1:0]     lane_addr,
  output logic                        busy,
`ifdef SKEW_SCHED_PERF_EN
  output logic [31:0]                 perf_cycles,
`endif
  output logic                        done
);

  localparam int LW = $clog2(DEPTH + 1);
  // Feed counter must reach DEPTH+LANES-1 without wrapping.
  localparam int CW = $clog2(DEPTH + LANES);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DRAIN_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cyc;
  logic [LW-1:0]  len;
  logic [DW-1:0]  dcnt;
  logic [LW-1:0]  len_clip;
  logic           feed_last;
  logic           drain_last;

  assign len_clip   = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
  // The last feed cycle is cyc = len+LANES-2; compare cyc+1 against len+LANES-1 so LANES=1 never goes negative.
  assign feed_last  = (({1'b0, cyc} + (CW+1)'(1)) == ({1'b0, CW'(len)} + (CW+1)'(LANES - 1)));
  assign drain_last = (dcnt == DW'(DRAIN_LAST));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort has priority over everything while a job runs.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cfg_len != '0) ? FEED : DONE;
        end
      end
      FEED: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (feed_last) begin
          state_nxt = (PIPE_LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (drain_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Job length latch, feed cycle counter and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= '0;
      len  <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cyc  <= '0;
            len  <= len_clip;
            dcnt <= '0;
          end
        end
        FEED: begin
          cyc  <= cyc + CW'(1);
          dcnt <= '0;
        end
        DRAIN: begin
          if (!drain_last) begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Lane i reads address cyc-i during its len-cycle window, giving the diagonal skew.
  always_comb begin
    lane_ren_n = '1;
    lane_addr  = '0;
    if (state == FEED) begin
      for (int i = 0; i < LANES; i++) begin
        if ((cyc >= CW'(i)) && ((cyc - CW'(i)) < CW'(len))) begin
          lane_ren_n[i]                 = 1'b0;
          lane_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(cyc - CW'(i));
        end
      end
    end
  end

  assign busy = (state == FEED) || (state == DRAIN);
  assign done = (state == DONE);

`ifdef SKEW_SCHED_PERF_EN
  // Busy-cycle counter: cleared by an accepted start, saturating, held when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_skew_scheduler.sv
// tb/tb_skew_scheduler.sv - randomized self-checking bench for skew_scheduler against a timeline model
module tb_skew_scheduler;

  localparam int LANES    = 4;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 8;
  localparam int PIPE_LAT = 4;
  localparam int LW       = $clog2(DEPTH + 1);
  localparam int OW       = 2 + LANES + LANES * ADDR_W;
  localparam logic [OW-1:0] RST_VEC = {1'b0, 1'b0, {LANES{1'b1}}, {(LANES*ADDR_W){1'b0}}};

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    abort;
  logic [LW-1:0]           cfg_len;
  logic [LANES-1:0]        lane_ren_n;
  logic [LANES*ADDR_W-1:0] lane_addr;
  logic                    busy;
  logic                    done;
`ifdef SKEW_SCHED_PERF_EN
  logic [31:0]             perf_cycles;
`endif
  logic [OW-1:0]           obs;

  int vectors     = 0;
  int miscompares = 0;

  // Model: job active flag, cycle number t since the start edge, clipped length.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_len    = 0;
  int unsigned m_perf   = 0;

  skew_scheduler #(
    .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_len    (cfg_len),
    .lane_ren_n (lane_ren_n),
    .lane_addr  (lane_addr),
    .busy       (busy),
`ifdef SKEW_SCHED_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, lane_ren_n, lane_addr};

  function automatic int done_t();
    return (m_len == 0) ? 1 : m_len + LANES + PIPE_LAT;
  endfunction

  // Expected outputs seen at cycle m_t of the current job.
  function automatic logic [OW-1:0] exp_vec();
    logic [LANES-1:0]        r;
    logic [LANES*ADDR_W-1:0] ad;
    logic                    b;
    logic                    d;
    int                      c;
    r  = '1;
    ad = '0;
    b  = 1'b0;
    d  = 1'b0;
    if (m_active) begin
      if (m_len > 0 && m_t <= m_len + LANES - 1 + PIPE_LAT) b = 1'b1;
      if (m_t == done_t()) d = 1'b1;
      if (m_len > 0 && m_t <= m_len + LANES - 1) begin
        c = m_t - 1;
        for (int i = 0; i < LANES; i++) begin
          if (c >= i && c <= i + m_len - 1) begin
            r[i] = 1'b0;
            ad[i*ADDR_W +: ADDR_W] = ADDR_W'(c - i);
          end
        end
      end
    end
    return {b, d, r, ad};
  endfunction

  // Apply inputs for the next edge and advance the model across that edge.
  task automatic drive(input logic s, input logic a, input int c);
    logic [OW-1:0] e;
    e       = exp_vec();
    start   = s;
    abort   = a;
    cfg_len = c[LW-1:0];
    if (!m_active && s) m_perf = 0;
    else if (e[OW-1]) m_perf = m_perf + 1;
    if (m_active) begin
      if (a && e[OW-1]) m_active = 1'b0;
      else if (m_t == done_t()) m_active = 1'b0;
      else m_t = m_t + 1;
    end else if (s) begin
      m_active = 1'b1;
      m_t      = 1;
      m_len    = (c > DEPTH) ? DEPTH : c;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== RST_VEC) begin
      miscompares++;
      $display("FAIL reset_state got %h exp %h", obs, RST_VEC);
    end
`ifdef SKEW_SCHED_PERF_EN
    vectors++;
    if (perf_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_perf got %0d exp 0", perf_cycles);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int done_n = 0;
    int done_k = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
      if (done) begin done_n++; done_k = k; end
`ifdef SKEW_SCHED_PERF_EN
      if (k == 11 || k == 15) begin
        vectors++;
        if (perf_cycles !== 32'd10) begin
          miscompares++;
          $display("FAIL basic_perf cyc=%0d got %0d exp 10", k, perf_cycles);
        end
      end
`endif
      drive(k == 0, 1'b0, 3);
    end
    vectors++;
    if (done_n !== 1 || done_k !== 11) begin
      miscompares++;
      $display("FAIL basic_done count=%0d at=%0d exp count=1 at=11", done_n, done_k);
    end
  endtask

  task automatic test_len_zero();
    int busy_n = 0;
    int done_k = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL len_zero cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
      if (busy) busy_n++;
      if (done) done_k = k;
      drive(k == 0, 1'b0, 0);
    end
    vectors++;
    if (busy_n !== 0 || done_k !== 1) begin
      miscompares++;
      $display("FAIL len_zero_done busy_cycles=%0d done_at=%0d exp 0 and 1", busy_n, done_k);
    end
  endtask

  task automatic test_len_over();
    int last_k = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL len_over cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
      if (lane_ren_n[3] == 1'b0) last_k = k;
      drive(k == 0, 1'b0, DEPTH + 3);
    end
    vectors++;
    if (last_k !== 11) begin
      miscompares++;
      $display("FAIL len_over_lane3 last=%0d exp 11", last_k);
    end
  endtask

  task automatic test_abort();
    int done_n = 0;
    int done_k = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL abort cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
      if (k == 6) begin
        vectors++;
        if (busy !== 1'b0 || lane_ren_n !== '1) begin
          miscompares++;
          $display("FAIL abort_idle busy=%b ren_n=%b exp 0 and 1111", busy, lane_ren_n);
        end
      end
      if (done) begin done_n++; done_k = k; end
      drive(k == 0 || k == 6, k == 5, 3);
    end
    vectors++;
    if (done_n !== 1 || done_k !== 17) begin
      miscompares++;
      $display("FAIL abort_done count=%0d at=%0d exp count=1 at=17", done_n, done_k);
    end
  endtask

  task automatic test_start_busy();
    int done_n = 0;
    int done_k = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL start_busy cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
      if (done) begin done_n++; done_k = k; end
      drive(k == 0 || k == 2 || k == 9, 1'b0, (k == 0) ? 3 : 7);
    end
    vectors++;
    if (done_n !== 1 || done_k !== 11) begin
      miscompares++;
      $display("FAIL start_busy_done count=%0d at=%0d exp count=1 at=11", done_n, done_k);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
      if (k == 4) begin
        rst_n = 1'b0;
        start = 1'b0;
        m_active = 1'b0;
        m_perf = 0;
        #1;
        vectors++;
        if (obs !== RST_VEC) begin
          miscompares++;
          $display("FAIL reset_mid_async got %h exp %h", obs, RST_VEC);
        end
      end else begin
        drive(k == 0, 1'b0, 3);
      end
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (obs !== RST_VEC) begin
        miscompares++;
        $display("FAIL reset_mid_hold got %h exp %h", obs, RST_VEC);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec() || done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
      drive(1'b0, 1'b0, 3);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got %h exp %h", k, obs, exp_vec());
      end
`ifdef SKEW_SCHED_PERF_EN
      vectors++;
      if (perf_cycles !== m_perf) begin
        miscompares++;
        $display("FAIL random_perf cyc=%0d got %0d exp %0d", k, perf_cycles, m_perf);
      end
`endif
      drive(($urandom % 4) == 0, ($urandom % 24) == 0, int'($urandom % 16));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_len_over();
    test_abort();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
